// File: rtl/light_latency_meter.sv
// Multi-channel light latency meter: raises stimulus, times each debounced sensor rise, streams per-channel results.
// Latency: result = D + SYNC_STAGES + DEBOUNCE_CYCLES - 1; results held stable while result_valid && !result_ready.
module light_latency_meter #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int COUNT_WIDTH     = 24,
   parameter int TIMEOUT_CYCLES  = 2**24-1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [CHANNELS-1:0]    sensor,
   output logic                   stimulus,
   output logic                   busy,
   output logic [CHANNELS-1:0]    light_on,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [3:0]             result_channel,
   output logic [COUNT_WIDTH-1:0] result_cycles,
   output logic                   result_timeout
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]        DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] TMO     = COUNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] TMO_M1  = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

   state_t                   state, state_nx;
   logic [CHANNELS-1:0]      synced, filt, filt_nx, rise, hit, hit_nx, timed;
   logic [COUNT_WIDTH-1:0]   cnt;
   logic [COUNT_WIDTH-1:0]   lat [CHANNELS];
   logic [3:0]               idx;
   logic                     cnt_last, idx_last;

   // Per-channel synchroniser and debouncer
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [DB_W-1:0]        db_cnt;
      logic                   filt_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sync_q <= '0;
            db_cnt <= '0;
            filt_q <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor[g]};
            if (synced[g] == filt_q || db_cnt == DB_LAST)
               db_cnt <= '0;
            else
               db_cnt <= db_cnt + DB_W'(1);
            filt_q <= filt_nx[g];
         end
      end

      assign synced[g]  = sync_q[SYNC_STAGES-1];
      assign filt[g]    = filt_q;
      assign filt_nx[g] = (synced[g] != filt_q && db_cnt == DB_LAST) ? ~filt_q : filt_q;
   end

   assign rise     = filt_nx & ~filt;
   assign hit_nx   = hit | rise;
   assign cnt_last = (cnt == TMO_M1);
   assign idx_last = (idx == 4'(CHANNELS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = ARM;
         ARM: begin
            if (light_on == '0)  state_nx = MEASURE;
            else if (cnt_last)   state_nx = REPORT;
         end
         MEASURE: if (&hit_nx || cnt_last) state_nx = REPORT;
         REPORT:  if (result_ready && idx_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      stimulus       = (state == MEASURE);
      busy           = (state != IDLE);
      result_valid   = (state == REPORT);
      result_channel = idx;
      result_cycles  = '0;
      result_timeout = 1'b0;
      if (state == REPORT) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (idx == 4'(i)) begin
               result_cycles  = lat[i];
               result_timeout = timed[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         light_on <= '0;
         cnt      <= '0;
         hit      <= '0;
         timed    <= '0;
         idx      <= '0;
         for (int i = 0; i < CHANNELS; i++) lat[i] <= '0;
      end else begin
         light_on <= filt;
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
            end
            ARM: begin
               hit   <= '0;
               timed <= '0;
               idx   <= '0;
               cnt   <= (state_nx == MEASURE) ? '0 : cnt + COUNT_WIDTH'(1);
               // Never went dark: every channel reports a timeout
               if (state_nx == REPORT) begin
                  timed <= '1;
                  for (int i = 0; i < CHANNELS; i++) lat[i] <= TMO;
               end
            end
            MEASURE: begin
               if (cnt != TMO) cnt <= cnt + COUNT_WIDTH'(1);
               hit <= hit_nx;
               idx <= '0;
               for (int i = 0; i < CHANNELS; i++) begin
                  if (rise[i] && !hit[i]) begin
                     lat[i] <= cnt;
                  end else if (state_nx == REPORT && !hit_nx[i]) begin
                     lat[i]   <= TMO;
                     timed[i] <= 1'b1;
                  end
               end
            end
            REPORT: begin
               if (result_ready && !idx_last) idx <= idx + 4'd1;
            end
            default: idx <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_light_latency_meter.sv
// Directed bench for light_latency_meter: vector table plus hand-written reset, ARM and glitch sequences.
module tb_light_latency_meter;

   localparam int CH = 4;
   localparam int CW = 24;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [CH-1:0] sensor = '0;
   logic          stimulus, busy, result_valid, result_timeout;
   logic          result_ready = 1'b0;
   logic [CH-1:0] light_on;
   logic [3:0]    result_channel;
   logic [CW-1:0] result_cycles;

   int pass_cnt = 0;
   int total_cnt = 0;
   int stim_cnt = 0;
   int stim_base = 0;

   typedef struct packed {
      logic [3:0][7:0] d;     // raw rise cycle per channel after stimulus, 0 = never
      logic [3:0][7:0] cyc;   // expected result_cycles per channel
      logic [3:0]      to;    // expected timeout flags
      logic            rnd;   // random result_ready
      logic [7:0]      stim;  // expected stimulus-high cycles
   } vec_t;

   vec_t vecs [5];

   light_latency_meter #(
      .CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
      .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(200)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .sensor(sensor),
      .stimulus(stimulus), .busy(busy), .light_on(light_on),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_channel(result_channel), .result_cycles(result_cycles),
      .result_timeout(result_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (stimulus) stim_cnt <= stim_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic chk_outs_zero(input string name);
      chk(name, 64'({stimulus, busy, light_on, result_valid, result_channel,
                     result_cycles, result_timeout}), 64'd0);
   endtask

   task automatic do_start();
      stim_base = stim_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_stim();
      bit ok = 1'b0;
      for (int g = 0; g < 400 && !ok; g++) begin
         @(negedge clk);
         if (stimulus) ok = 1'b1;
      end
      chk("stim_rise", 64'(ok), 64'd1);
   endtask

   // Called at the negedge of the first stimulus-high cycle; k counts edges since stimulus rose
   task automatic drive(input vec_t v, input int start_at, input bit glitch);
      int maxk = glitch ? 5 : 0;
      for (int c = 0; c < CH; c++) if (int'(v.d[c]) > maxk) maxk = int'(v.d[c]);
      for (int k = 1; k <= maxk; k++) begin
         @(posedge clk); #1;
         start = (k == start_at);
         for (int c = 0; c < CH; c++) if (int'(v.d[c]) == k) sensor[c] = 1'b1;
         if (glitch && k == 2) sensor[3] = 1'b1;
         if (glitch && k == 5) sensor[3] = 1'b0;
      end
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic collect(input vec_t v, input string tag);
      int n = 0;
      int guard = 0;
      bit pv = 1'b0;
      bit pr = 1'b0;
      logic [3:0]    pch = '0;
      logic [CW-1:0] pcy = '0;
      logic          pto = 1'b0;
      while (n < CH && guard < 2000) begin
         @(posedge clk); #1 result_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         guard++;
         if (result_valid) begin
            if (pv && !pr) begin
               chk({tag, "_stall_dat"}, 64'({result_channel, result_cycles, result_timeout}),
                   64'({pch, pcy, pto}));
            end
            if (result_ready) begin
               chk({tag, "_ch"}, 64'(result_channel), 64'(n));
               chk({tag, "_cycles"}, 64'(result_cycles), 64'(v.cyc[n]));
               chk({tag, "_timeout"}, 64'(result_timeout), 64'(v.to[n]));
               n++;
            end
            pv = 1'b1; pr = result_ready;
            pch = result_channel; pcy = result_cycles; pto = result_timeout;
         end else begin
            pv = 1'b0;
         end
      end
      if (guard >= 2000) chk({tag, "_collect_bound"}, 64'(n), 64'(CH));
      @(posedge clk); #1 result_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_done_idle"}, 64'({result_valid, busy}), 64'd0);
      chk({tag, "_stim_len"}, 64'(stim_cnt - stim_base), 64'(v.stim));
   endtask

   task automatic cleanup();
      sensor = '0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag, input int start_at);
      do_start();
      wait_stim();
      drive(v, start_at, 1'b0);
      collect(v, tag);
      cleanup();
   endtask

   initial begin
      bit seen;
      int k;

      //            d {ch3..ch0}             cyc {ch3..ch0}                to       rnd   stim
      vecs[0] = '{d:{8'd40,8'd30,8'd20,8'd10}, cyc:{8'd45,8'd35,8'd25,8'd15},   to:4'b0000, rnd:1'b0, stim:8'd46};
      vecs[1] = '{d:{8'd0,8'd0,8'd10,8'd0},    cyc:{8'd200,8'd200,8'd15,8'd200}, to:4'b1101, rnd:1'b0, stim:8'd200};
      vecs[2] = '{d:{8'd30,8'd12,8'd20,8'd12}, cyc:{8'd35,8'd17,8'd25,8'd17},   to:4'b0000, rnd:1'b1, stim:8'd36};
      vecs[3] = '{d:{8'd50,8'd3,8'd5,8'd1},    cyc:{8'd55,8'd8,8'd10,8'd6},     to:4'b0000, rnd:1'b1, stim:8'd56};
      vecs[4] = '{d:{8'd0,8'd10,8'd10,8'd10},  cyc:{8'd200,8'd15,8'd15,8'd15},  to:4'b1000, rnd:1'b0, stim:8'd200};

      #1 reset = 1'b1;
      #1 chk_outs_zero("reset_outs");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_outs_zero("post_reset_outs");

      for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

      // ch0 lit when start arrives: ARM holds until light_on clears, then a ch3 glitch in MEASURE
      sensor[0] = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("lit_light_on", 64'(light_on), 64'd1);
      do_start();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("arm_hold", 64'({busy, stimulus}), 64'b10);
      end
      @(posedge clk); #1 sensor[0] = 1'b0;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 50) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (stimulus) seen = 1'b1;
      end
      chk("arm_delay", 64'(k), 64'd8);
      drive(vecs[4], 0, 1'b1);
      collect(vecs[4], "glitch");
      cleanup();

      // start during MEASURE is ignored
      vecs[0] = '{d:{8'd5,8'd5,8'd5,8'd5}, cyc:{8'd10,8'd10,8'd10,8'd10}, to:4'b0000, rnd:1'b0, stim:8'd11};
      run_vec(vecs[0], "ign_start", 3);
      chk("ign_start_idle", 64'(busy), 64'd0);

      // reset during MEASURE
      do_start();
      wait_stim();
      repeat (7) @(posedge clk);
      #2 reset = 1'b1;
      #1 chk_outs_zero("rst_measure_outs");
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_measure_idle", 64'({busy, result_valid}), 64'd0);

      // reset during REPORT
      vecs[1] = '{d:{8'd3,8'd3,8'd3,8'd3}, cyc:{8'd8,8'd8,8'd8,8'd8}, to:4'b0000, rnd:1'b0, stim:8'd9};
      do_start();
      wait_stim();
      drive(vecs[1], 0, 1'b0);
      seen = 1'b0;
      for (int g = 0; g < 100 && !seen; g++) begin
         @(negedge clk);
         if (result_valid) seen = 1'b1;
      end
      chk("rpt_valid", 64'({seen, result_channel, result_cycles}), 64'({1'b1, 4'd0, 24'd8}));
      result_ready = 1'b1;
      @(posedge clk); #1 result_ready = 1'b0;
      @(negedge clk);
      chk("rpt_second", 64'({result_valid, result_channel}), 64'({1'b1, 4'd1}));
      sensor = '0;
      #2 reset = 1'b1;
      #1 chk_outs_zero("rst_report_outs");
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_report_idle", 64'({busy, result_valid}), 64'd0);
      cleanup();

      // fresh measurement after resets
      vecs[2] = '{d:{8'd40,8'd30,8'd20,8'd10}, cyc:{8'd45,8'd35,8'd25,8'd15}, to:4'b0000, rnd:1'b0, stim:8'd46};
      run_vec(vecs[2], "fresh", 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
